// File: rtl/wb_pkg.sv
// Shared constants and bundle layout for the MEM/WB pipeline register.
// Channel k of a packed bundle sits at [k*AW +: AW] / [k*DW +: DW].
package wb_pkg;

  localparam int NCH_DEF = 2;
  localparam int AW_DEF  = 5;
  localparam int DW_DEF  = 32;

  typedef struct packed {
    logic              wreg;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wb_ch_t;

endpackage

// File: rtl/mem_wb_skid.sv
// One-entry skid buffer holding a sanitised write-back bundle.
// Filled while the output is held, drained when the output moves.
module mem_wb_skid
  import wb_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [NCH-1:0]    in_wreg,
  input  logic [NCH*AW-1:0] in_addr,
  input  logic [NCH*DW-1:0] in_data,
  output logic              full,
  output logic [NCH-1:0]    wreg,
  output logic [NCH*AW-1:0] addr,
  output logic [NCH*DW-1:0] data
);

  // entry state: flush/pop empty it, push fills it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
      wreg <= '0;
      addr <= '0;
      data <= '0;
    end else if (flush) begin
      full <= 1'b0;
      wreg <= '0;
    end else if (push) begin
      full <= 1'b1;
      wreg <= in_wreg;
      addr <= in_addr;
      data <= in_data;
    end else if (pop) begin
      full <= 1'b0;
      wreg <= '0;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM->WB pipeline register with load-time write-enable sanitising.
// Define MEM_WB_SKID_EN for a registered o_ready with a one-entry skid.
module mem_wb_pipe
  import wb_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [NCH-1:0]    i_wreg,
  input  logic [NCH*AW-1:0] i_wreg_addr,
  input  logic [NCH*DW-1:0] i_wreg_data,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [NCH-1:0]    o_wreg,
  output logic [NCH*AW-1:0] o_wreg_addr,
  output logic [NCH*DW-1:0] o_wreg_data
);

  logic [NCH-1:0]    san_wreg;
  logic              out_move;
  logic              accept;
  logic              load;
  logic [NCH-1:0]    ld_wreg;
  logic [NCH*AW-1:0] ld_addr;
  logic [NCH*DW-1:0] ld_data;

  // drop writes to r0 and writes shadowed by a higher channel
  always_comb begin
    san_wreg = '0;
    for (int k = 0; k < NCH; k++) begin
      san_wreg[k] = i_wreg[k] &&
        (i_wreg_addr[k*AW +: AW] != '0);
      for (int j = k + 1; j < NCH; j++) begin
        if (i_wreg[j] &&
            i_wreg_addr[j*AW +: AW] ==
            i_wreg_addr[k*AW +: AW])
          san_wreg[k] = 1'b0;
      end
    end
  end

  assign out_move = !o_valid || i_ready;
  assign accept   = i_valid && o_ready;

`ifdef MEM_WB_SKID_EN
  logic              skid_full;
  logic [NCH-1:0]    skid_wreg;
  logic [NCH*AW-1:0] skid_addr;
  logic [NCH*DW-1:0] skid_data;

  assign o_ready = !skid_full;

  mem_wb_skid #(
    .NCH(NCH),
    .AW (AW),
    .DW (DW)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .push   (accept && !out_move),
    .pop    (out_move && skid_full),
    .flush  (i_flush),
    .in_wreg(san_wreg),
    .in_addr(i_wreg_addr),
    .in_data(i_wreg_data),
    .full   (skid_full),
    .wreg   (skid_wreg),
    .addr   (skid_addr),
    .data   (skid_data)
  );

  assign load    = out_move && (skid_full || accept);
  assign ld_wreg = skid_full ? skid_wreg : san_wreg;
  assign ld_addr = skid_full ? skid_addr : i_wreg_addr;
  assign ld_data = skid_full ? skid_data : i_wreg_data;
`else
  assign o_ready = out_move;
  assign load    = accept;
  assign ld_wreg = san_wreg;
  assign ld_addr = i_wreg_addr;
  assign ld_data = i_wreg_data;
`endif

  // output register: flush beats load, idle move empties it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid     <= 1'b0;
      o_wreg      <= '0;
      o_wreg_addr <= '0;
      o_wreg_data <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      o_wreg  <= '0;
    end else if (load) begin
      o_valid     <= 1'b1;
      o_wreg      <= ld_wreg;
      o_wreg_addr <= ld_addr;
      o_wreg_data <= ld_data;
    end else if (out_move) begin
      o_valid <= 1'b0;
      o_wreg  <= '0;
    end
  end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe (default NCH=2, AW=5, DW=32).
// Builds with or without MEM_WB_SKID_EN.
module tb_mem_wb_pipe;

`ifdef MEM_WB_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_wreg;
  logic [9:0]  i_wreg_addr;
  logic [63:0] i_wreg_data;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [1:0]  o_wreg;
  logic [9:0]  o_wreg_addr;
  logic [63:0] o_wreg_data;

  mem_wb_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_wreg     (i_wreg),
    .i_wreg_addr(i_wreg_addr),
    .i_wreg_data(i_wreg_data),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_wreg     (o_wreg),
    .o_wreg_addr(o_wreg_addr),
    .o_wreg_data(o_wreg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  w;
    logic [9:0]  a;
    logic [63:0] d;
  } bundle_t;

  typedef struct {
    logic [1:0]  w;
    logic [9:0]  a;
    logic [63:0] d;
    logic [1:0]  ew;
  } vec_t;

  int checks = 0;
  int errors = 0;
  bundle_t q[$];
  bit acc_flag;
  int emitted;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // surviving enables: last enabled writer of each non-zero address
  function automatic logic [1:0] ref_en(input logic [1:0] w,
                                        input logic [9:0] a);
    int owner [int];
    logic [1:0] r;
    int ak;
    r = '0;
    for (int k = 0; k < 2; k++)
      if (w[k]) owner[int'(a[k*5 +: 5])] = k;
    for (int k = 0; k < 2; k++) begin
      ak = int'(a[k*5 +: 5]);
      r[k] = w[k] && ak != 0 && owner.exists(ak) && owner[ak] == k;
    end
    return r;
  endfunction

  // drive one cycle, check outputs against the queue model, advance
  task automatic step(input logic v, input logic r, input logic f,
                      input logic [1:0] w, input logic [9:0] a,
                      input logic [63:0] d);
    bit exp_rdy;
    bundle_t b;
    i_valid = v; i_ready = r; i_flush = f;
    i_wreg = w; i_wreg_addr = a; i_wreg_data = d;
    #2;
    exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || r);
    chk("o_ready", 128'(o_ready), 128'(exp_rdy));
    chk("o_valid", 128'(o_valid), 128'(q.size() > 0));
    if (q.size() > 0) begin
      chk("o_wreg", 128'(o_wreg), 128'(q[0].w));
      chk("o_addr", 128'(o_wreg_addr), 128'(q[0].a));
      chk("o_data", 128'(o_wreg_data), 128'(q[0].d));
    end else begin
      chk("o_wreg_idle", 128'(o_wreg), 128'(0));
    end
    if (o_valid && r) emitted++;
    acc_flag = v && exp_rdy;
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (q.size() > 0 && r) void'(q.pop_front());
      if (acc_flag) begin
        b.w = ref_en(w, a); b.a = a; b.d = d;
        q.push_back(b);
      end
    end
    #1;
  endtask

  vec_t tbl[6];
  bundle_t prod[$];
  bundle_t pb;
  int stall_acc;

  initial begin
    tbl[0] = '{2'b01, {5'd0, 5'd3}, {32'h0, 32'hDEAD_BEEF}, 2'b01};
    tbl[1] = '{2'b11, {5'd7, 5'd0}, {32'h2, 32'h1}, 2'b10};
    tbl[2] = '{2'b11, {5'd9, 5'd9}, {32'hB, 32'hA}, 2'b10};
    tbl[3] = '{2'b11, {5'd5, 5'd4}, {32'h55, 32'h44}, 2'b11};
    tbl[4] = '{2'b10, {5'd0, 5'd6}, {32'h66, 32'h77}, 2'b00};
    tbl[5] = '{2'b01, {5'd31, 5'd31}, {32'h1F, 32'hF1}, 2'b01};

    rst = 1'b0; i_valid = 1'b1; i_ready = 1'b0; i_flush = 1'b0;
    i_wreg = 2'b11; i_wreg_addr = 10'h3FF; i_wreg_data = '1;
    emitted = 0;
    #2;
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_wreg", 128'(o_wreg), 128'(0));
    chk("rst_addr", 128'(o_wreg_addr), 128'(0));
    chk("rst_data", 128'(o_wreg_data), 128'(0));
    @(posedge clk); @(posedge clk); #1;
    chk("rst_hold_valid", 128'(o_valid), 128'(0));
    rst = 1'b1;

    // table vectors: single bundle, then idle cycle
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, tbl[i].w, tbl[i].a, tbl[i].d);
      chk("tbl_valid", 128'(o_valid), 128'(1));
      chk("tbl_wreg", 128'(o_wreg), 128'(tbl[i].ew));
      chk("tbl_addr", 128'(o_wreg_addr), 128'(tbl[i].a));
      chk("tbl_data", 128'(o_wreg_data), 128'(tbl[i].d));
      step(0, 1, 0, 2'b00, 10'd0, 64'd0);
      chk("tbl_next_valid", 128'(o_valid), 128'(0));
    end

    // stall: 3 cycles ready low while 4 bundles stream
    for (int i = 0; i < 4; i++) begin
      pb.w = 2'b11;
      pb.a = {5'(i + 11), 5'(i + 1)};
      pb.d = {32'(32'hC000 + i), 32'(32'hB000 + i)};
      prod.push_back(pb);
    end
    emitted = 0;
    stall_acc = 0;
    for (int c = 0; c < 20; c++) begin
      if (prod.size() > 0)
        step(1, c >= 3, 0, prod[0].w, prod[0].a, prod[0].d);
      else
        step(0, 1, 0, 2'b00, 10'd0, 64'd0);
      if (acc_flag) begin
        void'(prod.pop_front());
        if (c < 3) stall_acc++;
      end
    end
    chk("stall_accepts", 128'(stall_acc), 128'(SKID ? 2 : 1));
    chk("stall_drained", 128'(prod.size()), 128'(0));
    chk("stall_emitted", 128'(emitted), 128'(4));

    // flush with the stage (and skid, if present) full
    step(1, 0, 0, 2'b01, {5'd0, 5'd2}, {32'h0, 32'h22});
    step(1, 0, 0, 2'b01, {5'd0, 5'd3}, {32'h0, 32'h33});
    step(1, 0, 1, 2'b01, {5'd0, 5'd4}, {32'h0, 32'h44});
    chk("flush_valid", 128'(o_valid), 128'(0));
    chk("flush_wreg", 128'(o_wreg), 128'(0));
    chk("flush_ready", 128'(o_ready), 128'(1));
    step(0, 1, 0, 2'b00, 10'd0, 64'd0);

    // reset pulsed mid-stall
    emitted = 0;
    step(1, 0, 0, 2'b11, {5'd8, 5'd7}, {32'h88, 32'h77});
    step(1, 0, 0, 2'b11, {5'd6, 5'd5}, {32'h66, 32'h55});
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(o_valid), 128'(0));
    chk("mid_rst_wreg", 128'(o_wreg), 128'(0));
    chk("mid_rst_data", 128'(o_wreg_data), 128'(0));
    q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 3; c++)
      step(0, 1, 0, 2'b00, 10'd0, 64'd0);
    chk("mid_rst_emitted", 128'(emitted), 128'(0));

    // randomized traffic against the queue model
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0,
           2'($urandom),
           {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))},
           {32'($urandom), 32'($urandom)});
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
